mem_arbiter: RTL
================

# mem_arbiter

Sequential arbiter and sequencer that shares one unified, variable-latency memory port between the instruction-fetch path (driven by the PC's `InstrAddr`) and the load/store path (driven by the decoder's `we`/`wstrobe` controls). It grants one requester at a time and drives a req/ack memory handshake. It returns read data and a one-cycle completion pulse to the winner. While any request is outstanding, it asserts `stall` so the PC and register-file write can be held.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, ack-wait limit in cycles (used only with `MEM_ARB_TIMEOUT_EN`)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch request, level, held until `if_valid`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched instruction
- `if_valid`  out  1  one-cycle fetch-complete pulse
- `ls_req`  in  1  load/store request, level, held until `ls_done`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  AW  data address
- `ls_wdata`  in  DW  store data
- `ls_wstrobe`  in  3  access size code, passed through unchanged
- `ls_rdata`  out  DW  load data
- `ls_done`  out  1  one-cycle load/store-complete pulse
- `mem_req`  out  1  memory request, level
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_wstrobe`  out  3  memory size code
- `mem_ack`  in  1  memory completion, sampled only while `mem_req` = 1
- `mem_rdata`  in  DW  memory read data, valid with `mem_ack`
- `bus_err`  out  1  one-cycle pulse, coincident with `if_valid`/`ls_done`, on timeout abort
- `stall`  out  1  combinational: `(if_req & ~if_valid) | (ls_req & ~ls_done)`

## Operation
FSM states and transitions:
- **IDLE**
  - `ls_req` = 1 → LS_BUSY.
  - Otherwise `if_req` = 1 → IF_BUSY.
  - Otherwise stay in IDLE.
- **Grant capture:** on the grant edge, the winner's addr/we/wdata/wstrobe are latched into `mem_*` registers. For a fetch, `mem_we` = 0 and `mem_wstrobe` = 3'b000. The registers hold stable for the whole transaction, even if inputs change.
- **IF_BUSY / LS_BUSY**
  - `mem_req` = 1.
  - When `mem_ack` is sampled 1: capture `mem_rdata` into `if_rdata` (fetch) or into `ls_rdata` (load only; unchanged for a store), drop `mem_req`, → RESP.
- **RESP**
  - The matching `if_valid` or `ls_done` is 1 for exactly this cycle.
  - No grant is made in RESP; this gives the requester one cycle to drop or renew its req.
  - → IDLE.
- **Priority:** fixed, load/store over fetch. If both requests are present in IDLE, LS wins and the fetch is granted on the next IDLE cycle.
- **Stray ack:** `mem_ack` in IDLE or RESP is ignored.
- **Read data hold:** `if_rdata` and `ls_rdata` hold their last value until overwritten.

## Timing
- Reset values: state = IDLE. All outputs are 0: `mem_*`, `if_rdata`, `ls_rdata`, `if_valid`, `ls_done`, `bus_err`, `mem_req`. `stall` follows its equation.
- Request seen in IDLE at cycle N:
  - `mem_req` = 1 from N+1.
  - Ack at cycle M ≥ N+1 → done/valid pulse at M+1, back in IDLE at M+2.
  - Minimum latency: 2 cycles request-to-done.
- Back-to-back throughput: one transaction per 3 cycles with zero-wait memory.
- Reset mid-transaction: IDLE on the reset edge, `mem_req` = 0, the pending ack is ignored, and no done pulse is produced.
- `stall` drops in the same cycle the done/valid pulse is high.

## Configuration
Macro: `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - An 8+ bit counter clears on grant and increments on each BUSY cycle with `mem_ack` = 0.
  - When the count reaches `TIMEOUT` with no ack, the transaction aborts: `mem_req` drops and the FSM goes → RESP with `bus_err` = 1.
  - On a fetch abort, `if_rdata` = 32'h0000_0013 (NOP).
  - On a load abort, `ls_rdata` = 0. On a store abort, `ls_rdata` is unchanged.
  - An ack in the same cycle the count reaches `TIMEOUT` takes precedence: normal completion, no error.
- **Undefined:** no counter; the FSM waits indefinitely for ack; `bus_err` is tied to 0.

## Test plan
- Reset, then fetch at 0x0000_0004 with 0-wait ack and `mem_rdata` = 0x0010_0093 → `mem_req` high at N+1, `if_valid` pulse at N+2 with `if_rdata` = 0x0010_0093.
- `if_req` and `ls_req` both high in IDLE, load at 0x100 and fetch at 0x8, 3-cycle ack each → LS served first with `ls_done`, then fetch; `stall` stays 1 until `if_valid`.
- Store `ls_we` = 1, addr 0x200, wdata 0xDEADBEEF, wstrobe 3'b100 → `mem_we` = 1 and `mem_*` stable across 5 wait cycles even when `ls_wdata` is changed mid-wait; `ls_rdata` unchanged.
- `rst` asserted during LS_BUSY, then a stray ack → `mem_req` = 0 after the reset edge, no `ls_done`, state IDLE.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT` = 4, fetch never acked → `bus_err` and `if_valid` pulse together, `if_rdata` = 0x0000_0013.
- Without the macro, ack withheld for 300 cycles → `mem_req` is held continuously and `bus_err` is never asserted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one req/ack memory port between instruction fetch and load/store, load/store first.
// Optional ack-wait timeout abort is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  input  logic [2:0]    ls_wstrobe,
  output logic [DW-1:0] ls_rdata,
  output logic          ls_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_wstrobe,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          bus_err,
  output logic          stall
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, RESP} state_t;

  state_t state;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [DW-1:0] NOP_INSN = DW'(32'h0000_0013);

  logic [CW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = (wait_cnt == CW'(TIMEOUT));
`else
  assign bus_err = 1'b0;
`endif

  // Held off only until the requester's own completion pulse.
  assign stall = (if_req & ~if_valid) | (ls_req & ~ls_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrobe <= 3'b000;
      if_rdata    <= '0;
      ls_rdata    <= '0;
      if_valid    <= 1'b0;
      ls_done     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err     <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      if_valid <= 1'b0;
      ls_done  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      bus_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Grant edge: the winner's request is frozen into the mem_* registers.
          if (ls_req) begin
            state       <= LS_BUSY;
            mem_req     <= 1'b1;
            mem_we      <= ls_we;
            mem_addr    <= ls_addr;
            mem_wdata   <= ls_wdata;
            mem_wstrobe <= ls_wstrobe;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end else if (if_req) begin
            state       <= IF_BUSY;
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= if_addr;
            mem_wdata   <= '0;
            mem_wstrobe <= 3'b000;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
        end
        IF_BUSY, LS_BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (state == IF_BUSY) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) ls_rdata <= mem_rdata;
              ls_done <= 1'b1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
          end else if (timed_out) begin
            // Abort: fetch sees a NOP, load sees zero, store leaves ls_rdata alone.
            mem_req <= 1'b0;
            state   <= RESP;
            bus_err <= 1'b1;
            if (state == IF_BUSY) begin
              if_rdata <= NOP_INSN;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) ls_rdata <= '0;
              ls_done <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
